i2c_target: RTL and testbench

Synthesizable I2C target (slave) responder. It is the bus-side counterpart of the APB-to-I2C controller and completes the loopback for directed tests. It oversamples SCL/SDA on a fast core clock, detects START/STOP, matches a 7-bit address, and serves a small register file. The file is written through write transfers and returned on read transfers. It mirrors the controller's `start`/`stop`/`data_out`/`valid` observation strobes so the bench can compare both ends.

---
 rtl/i2c_target.sv | 149 ++++++++++++++
 tb/tb_i2c_target.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, MEM_DEPTH-byte register file; I2C_TGT_AUTOINC_EN enables pointer auto-increment.
// Pin-to-event latency 3 clk_i cycles; no backpressure, the bus master paces every transfer.
module i2c_target #(
   parameter logic [6:0] TGT_ADDR  = 7'h3C,
   parameter int         MEM_DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic       start_o,
   output logic       stop_o,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       busy_o
);
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [3:0] {
      IDLE = 4'd0, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    scl_q, sda_q;
   logic [2:0]    bitcnt;
   logic [6:0]    shift;
   logic          rw;
   logic [AW-1:0] ptr;
   logic [7:0]    mem [MEM_DEPTH];

   logic       scl_s, scl_h, sda_s, sda_h;
   logic       start_det, stop_det, scl_rise, scl_fall, byte_end, addr_hit;
   logic [7:0] rx_byte, rd_byte;
   logic       sda_oe_nxt, start_nxt, stop_nxt, valid_nxt, busy_nxt;

   // stage [1] is the synchronised level, stage [2] its one-cycle history
   assign scl_s     = scl_q[1];
   assign scl_h     = scl_q[2];
   assign sda_s     = sda_q[1];
   assign sda_h     = sda_q[2];
   assign start_det = scl_s && scl_h && sda_h && !sda_s;
   assign stop_det  = scl_s && scl_h && !sda_h && sda_s;
   assign scl_rise  = scl_s && !scl_h;
   assign scl_fall  = !scl_s && scl_h;
   assign rx_byte   = {shift, sda_s};
   assign byte_end  = scl_rise && (bitcnt == 3'd7);
   assign addr_hit  = (rx_byte[7:1] == TGT_ADDR);
   assign rd_byte   = mem[ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         sda_oe_o <= 1'b0;
         start_o  <= 1'b0;
         stop_o   <= 1'b0;
         valid_o  <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         state    <= state_nxt;
         sda_oe_o <= sda_oe_nxt;
         start_o  <= start_nxt;
         stop_o   <= stop_nxt;
         valid_o  <= valid_nxt;
         busy_o   <= busy_nxt;
      end
   end

   // ACK states see two SCL falls: the first starts the ACK drive, the second ends it
   always_comb begin
      state_nxt = state;
      if (start_det) begin
         state_nxt = ADDR;
      end else if (stop_det) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            ADDR:     if (byte_end) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK: if (scl_fall && sda_oe_o) state_nxt = rw ? RD : PTR;
            PTR:      if (byte_end) state_nxt = PTR_ACK;
            PTR_ACK:  if (scl_fall && sda_oe_o) state_nxt = WR;
            WR:       if (byte_end) state_nxt = WR_ACK;
            WR_ACK:   if (scl_fall && sda_oe_o) state_nxt = WR;
            RD:       if (byte_end) state_nxt = RD_ACK;
            RD_ACK:   if (scl_rise) state_nxt = sda_s ? WAIT_STOP : RD;
            default:  state_nxt = state;
         endcase
      end
   end

   always_comb begin
      sda_oe_nxt = sda_oe_o;
      start_nxt  = 1'b0;
      stop_nxt   = 1'b0;
      valid_nxt  = 1'b0;
      busy_nxt   = busy_o;
      if (start_det) begin
         sda_oe_nxt = 1'b0;
         start_nxt  = 1'b1;
         busy_nxt   = 1'b1;
      end else if (stop_det) begin
         sda_oe_nxt = 1'b0;
         stop_nxt   = 1'b1;
         busy_nxt   = 1'b0;
      end else begin
         case (state)
            // a read address hands straight over to driving bit 7 of the first byte
            ADDR_ACK:        if (scl_fall) sda_oe_nxt = !sda_oe_o || (rw && !rd_byte[7]);
            PTR_ACK, WR_ACK: if (scl_fall) sda_oe_nxt = !sda_oe_o;
            WR:              valid_nxt = byte_end;
            RD:              if (scl_fall) sda_oe_nxt = !rd_byte[~bitcnt];
            RD_ACK:          if (scl_fall) sda_oe_nxt = 1'b0;
            default:         sda_oe_nxt = sda_oe_o;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_q  <= '1;
         sda_q  <= '1;
         bitcnt <= '0;
         shift  <= '0;
         rw     <= 1'b0;
         ptr    <= '0;
         data_o <= 8'h00;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
         if (start_det) begin
            bitcnt <= '0;
         end else if (scl_rise && (state inside {ADDR, PTR, WR, RD})) begin
            bitcnt <= bitcnt + 3'd1;
            shift  <= rx_byte[6:0];
         end
         if (state == ADDR && byte_end) rw <= rx_byte[0];
         if (state == PTR && byte_end) ptr <= rx_byte[AW-1:0];
         if (state == WR && byte_end) begin
            mem[ptr] <= rx_byte;
            data_o   <= rx_byte;
         end
`ifdef I2C_TGT_AUTOINC_EN
         if ((state == WR_ACK && scl_fall && sda_oe_o) || (state == RD_ACK && scl_rise))
            ptr <= ptr + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master with a wired-AND SDA and a strobe scoreboard.
module tb_i2c_target;
   localparam int Q = 10;
`ifdef I2C_TGT_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe, start_p, stop_p, valid_p, busy;
   logic [7:0] data;
   logic       sda_bus;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_dat[$];
   int         exp_evt[$];   // 1 = START, 2 = STOP
   logic       valid_q = 1'b0, start_q = 1'b0, stop_q = 1'b0;
   logic       oe_watch = 1'b0, oe_seen = 1'b0;
   logic [8:0] mon_d;
   int         mon_k;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_target #(.TGT_ADDR(7'h3C), .MEM_DEPTH(16)) dut (
      .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_oe_o(sda_oe), .start_o(start_p), .stop_o(stop_p),
      .data_o(data), .valid_o(valid_p), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: pops an expectation whenever the target presents a strobe
   always @(negedge clk) begin
      if (valid_p) begin
         chk("valid_width", valid_q, 0);
         mon_d = 9'h1FF;
         if (exp_dat.size() != 0) mon_d = {1'b0, exp_dat.pop_front()};
         chk("valid_data", {1'b0, data}, mon_d);
      end
      if (start_p) begin
         chk("start_width", start_q, 0);
         mon_k = 0;
         if (exp_evt.size() != 0) mon_k = exp_evt.pop_front();
         chk("start_event", mon_k, 1);
      end
      if (stop_p) begin
         chk("stop_width", stop_q, 0);
         mon_k = 0;
         if (exp_evt.size() != 0) mon_k = exp_evt.pop_front();
         chk("stop_event", mon_k, 2);
      end
      if (oe_watch && sda_oe) oe_seen = 1'b1;
      valid_q = valid_p;
      start_q = start_p;
      stop_q  = stop_p;
   end

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      exp_evt.push_back(1);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      exp_evt.push_back(2);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         sda_m = b[i]; wq(Q);
         scl_m = 1'b1; wq(2 * Q);
         scl_m = 1'b0; wq(Q);
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      ack = ~sda_bus; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic read_bits(input int nbits, output logic [7:0] b);
      b = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         sda_m = 1'b1; wq(Q);
         scl_m = 1'b1; wq(Q);
         b[i] = sda_bus; wq(Q);
         scl_m = 1'b0; wq(Q);
      end
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      read_bits(8, b);
      sda_m = ~mack; wq(Q);
      scl_m = 1'b1; wq(2 * Q);
      scl_m = 1'b0; wq(Q);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;

      wq(5);
      rst = 1'b0;
      wq(2);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_start", start_p, 0);
      chk("rst_stop", stop_p, 0);
      chk("rst_valid", valid_p, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", data, 8'h00);
      chk("rst_ptr", dut.ptr, 0);
      chk("rst_state", dut.state, 0);

      // write 0xA5, 0x5A from pointer 2
      exp_dat.push_back(8'hA5);
      exp_dat.push_back(8'h5A);
      i2c_start();
      chk("wr_busy", busy, 1);
      write_byte(8'h78, ack); chk("wr_ack_addr", ack, 1);
      write_byte(8'h02, ack); chk("wr_ack_ptr", ack, 1);
      write_byte(8'hA5, ack); chk("wr_ack_d0", ack, 1);
      write_byte(8'h5A, ack); chk("wr_ack_d1", ack, 1);
      i2c_stop();
      chk("wr_busy_after", busy, 0);
      chk("wr_mem2", dut.mem[2], AUTOINC ? 8'hA5 : 8'h5A);
      chk("wr_mem3", dut.mem[3], AUTOINC ? 8'h5A : 8'h00);

      // pointer write, repeated START, read two bytes
      i2c_start();
      write_byte(8'h78, ack); chk("rd_ack_waddr", ack, 1);
      write_byte(8'h02, ack); chk("rd_ack_ptr", ack, 1);
      i2c_start();
      write_byte(8'h79, ack); chk("rd_ack_raddr", ack, 1);
      read_byte(1'b1, rb); chk("rd_byte0", rb, AUTOINC ? 8'hA5 : 8'h5A);
      read_byte(1'b0, rb); chk("rd_byte1", rb, 8'h5A);
      i2c_stop();
      chk("rd_ptr_after", dut.ptr, AUTOINC ? 4 : 2);

      // foreign address: never driven, nothing stored
      oe_watch = 1'b1;
      i2c_start();
      write_byte(8'h7A, ack); chk("mis_ack_addr", ack, 0);
      write_byte(8'h11, ack); chk("mis_ack_data", ack, 0);
      i2c_stop();
      oe_watch = 1'b0;
      chk("mis_oe_seen", oe_seen, 0);
      chk("mis_mem1", dut.mem[1], 8'h00);
      chk("mis_mem2", dut.mem[2], AUTOINC ? 8'hA5 : 8'h5A);

      // pointer wrap from the last entry
      exp_dat.push_back(8'h11);
      exp_dat.push_back(8'h22);
      i2c_start();
      write_byte(8'h78, ack); chk("wrap_ack_addr", ack, 1);
      write_byte(8'h0F, ack); chk("wrap_ack_ptr", ack, 1);
      write_byte(8'h11, ack); chk("wrap_ack_d0", ack, 1);
      write_byte(8'h22, ack); chk("wrap_ack_d1", ack, 1);
      i2c_stop();
      chk("wrap_mem15", dut.mem[15], AUTOINC ? 8'h11 : 8'h22);
      chk("wrap_mem0", dut.mem[0], AUTOINC ? 8'h22 : 8'h00);

      // reset while driving bit 3 of a 0x00 byte (mem[5])
      i2c_start();
      write_byte(8'h78, ack); chk("rrst_ack_waddr", ack, 1);
      write_byte(8'h05, ack); chk("rrst_ack_ptr", ack, 1);
      i2c_start();
      write_byte(8'h79, ack); chk("rrst_ack_raddr", ack, 1);
      read_bits(4, rb); chk("rrst_hi_nibble", rb, 8'h00);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(3);
      chk("rrst_bit3_driven", sda_oe, 1);
      rst = 1'b1;
      wq(1);
      chk("rrst_sda_oe", sda_oe, 0);
      chk("rrst_busy", busy, 0);
      chk("rrst_data", data, 8'h00);
      chk("rrst_strobes", {start_p, stop_p, valid_p}, 3'b000);
      chk("rrst_ptr", dut.ptr, 0);
      chk("rrst_mem15", dut.mem[15], 8'h00);
      wq(1);
      rst = 1'b0;
      wq(2);
      scl_m = 1'b0; wq(Q);
      i2c_start();
      write_byte(8'h78, ack); chk("rrst_ack_after", ack, 1);
      i2c_stop();

      // STOP after 4 bits of a write byte
      i2c_start();
      write_byte(8'h78, ack); chk("sib_ack_addr", ack, 1);
      write_byte(8'h03, ack); chk("sib_ack_ptr", ack, 1);
      send_bits(8'hFF, 4);
      i2c_stop();
      wq(Q);
      chk("sib_mem3", dut.mem[3], 8'h00);
      chk("sib_state", dut.state, 0);
      chk("sib_busy", busy, 0);
      chk("sib_data", data, 8'h00);

      wq(Q);
      chk("dat_queue_left", exp_dat.size(), 0);
      chk("evt_queue_left", exp_evt.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
